mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single read/write port of the synchronous 16-bit Memory block between two requesters:
  - the CPU FSM (instruction fetch, load, store);
  - an IO requester (SNES button writer / future DMA).
- Sits between those requesters and Memory port A in Datapath.
- Policy: CPU priority, with an anti-starvation counter and a bounded IO burst lock.
- Returns read data to whichever requester owned the access, with fixed 1-cycle latency.

Parameters:
- ADDR_WIDTH, 16, address width of every address port.
- DATA_WIDTH, 16, data width of every data port.
- MAX_WAIT, 4, consecutive denied IO cycles before IO is forced to win (range 1..15).
- BURST_MAX, 8, maximum consecutive IO grants while io_lock is held (range 1..15).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU requests an access this cycle.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_WIDTH  CPU address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_gnt  out  1  CPU access issued this cycle (combinational).
- cpu_rvalid  out  1  CPU read data valid (registered).
- cpu_rdata  out  DATA_WIDTH  CPU read data.
- io_req  in  1  IO requests an access this cycle.
- io_we  in  1  1 = write, 0 = read.
- io_lock  in  1  IO requests to keep ownership for a burst.
- io_addr  in  ADDR_WIDTH  IO address.
- io_wdata  in  DATA_WIDTH  IO write data.
- io_gnt  out  1  IO access issued this cycle (combinational).
- io_rvalid  out  1  IO read data valid (registered).
- io_rdata  out  DATA_WIDTH  IO read data.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after the address is presented.

Behaviour:
- Reset (reset low, asynchronous): state ARB, wait_cnt 0, burst_cnt 0, both rvalid 0, pending-read owner none.
  - Combinational outputs while reset is low: gnt 0, mem_we 0, mem_addr 0, mem_wdata 0.
- One access per cycle; at most one gnt high per cycle.
- Winner's we/addr/wdata drive mem_* combinationally in the grant cycle.
- No grant: mem_we 0; mem_addr and mem_wdata hold their last driven values. A registered copy is required.
- State ARB:
  - Both requesting and wait_cnt == MAX_WAIT: IO wins.
  - Both requesting, otherwise: CPU wins.
  - Single requester: it wins.
  - IO wins with io_lock = 1: go to IO_BURST, burst_cnt = 1.
- State IO_BURST:
  - IO wins unconditionally while io_req and io_lock are both 1 and burst_cnt < BURST_MAX; burst_cnt increments per grant.
  - Return to ARB when io_lock or io_req drops, or burst_cnt == BURST_MAX.
  - In the exit cycle, arbitration uses the ARB rules.
  - Exiting on BURST_MAX: next ARB cycle treats wait_cnt as 0, so CPU wins if requesting.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) each cycle io_req = 1 and io_gnt = 0.
  - Clears on io_gnt.
  - Holds when io_req = 0.
- Read return:
  - A granted read with we = 0 sets the owner's rvalid in the next cycle.
  - In that cycle the owner's rdata equals mem_rdata (combinational pass-through).
  - rvalid is high for exactly 1 cycle per read.
  - Back-to-back reads give back-to-back rvalid, attributed per-cycle to the correct owner.
- Writes produce no rvalid.
- The non-owner's rdata holds its previous value; never glitches to the other owner's data.
- Reset asserted mid-access: in-flight rvalid is dropped and the access is not retried.
- A requester must hold req and its fields stable until it sees gnt. The arbiter does not latch un-granted requests.

Decomposition:
- Shared package (arb_pkg): state encoding constants ARB = 1'b0, IO_BURST = 1'b1; owner encoding OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_IO = 2'd2.
- One natural sub-module: arb_starve_counter (wait_cnt with saturate/clear, MAX_WAIT parameter).
- Grant logic, burst FSM and read-return tracking stay in the top module.

Test Plan:
- Reset low, all req 0 → gnt 0/0, mem_we 0, rvalid 0/0.
- Release reset; CPU read addr 0x0010, mem_rdata = 0xBEEF next cycle → cpu_gnt 1 in cycle N, cpu_rvalid 1 and cpu_rdata 0xBEEF in N+1, io_rvalid 0.
- cpu_req and io_req held high continuously, MAX_WAIT = 4 → CPU granted cycles 0–3, IO granted cycle 4, CPU again cycle 5, pattern repeats every 5 cycles.
- IO write burst, io_lock high, 10 requests, BURST_MAX = 8, cpu_req high → IO granted 8 consecutive cycles (mem_we 1, addresses 0x0100..0x0107), then CPU granted 1 cycle, then IO resumes.
- Alternating reads: CPU read 0x0001 then IO read 0x0002 back-to-back (mem_rdata 0x1111, 0x2222) → cpu_rvalid with 0x1111 then io_rvalid with 0x2222 on consecutive cycles; other rdata unchanged.
- CPU read granted, reset pulsed low before next edge → no cpu_rvalid after reset release, state ARB, wait_cnt 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types for the memory port arbiter: arbitration state, read-owner tags
// and the width used by the wait/burst counters.
package arb_pkg;

  typedef enum logic {
    ARB      = 1'b0,
    IO_BURST = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_IO   = 2'd2
  } owner_e;

  // Wide enough for MAX_WAIT and BURST_MAX up to 15.
  localparam int CNT_W = 4;

  // Who gets the read data that comes back next cycle.
  function automatic owner_e read_owner(input logic cpu_win, input logic cpu_we,
                                        input logic io_win, input logic io_we);
    if (cpu_win && !cpu_we) return OWN_CPU;
    if (io_win && !io_we) return OWN_IO;
    return OWN_NONE;
  endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Counts consecutive cycles the IO requester was denied; saturates at MAX_WAIT
// and flags starvation so the arbiter can force an IO win.
module arb_starve_counter
  import arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic io_req,
  input  logic io_gnt,
  output logic starved
);

  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt;

  assign starved = (wait_cnt == WAIT_LIM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (io_gnt) begin
      wait_cnt <= '0;
    end else if (io_req && !starved) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single Memory port A between the CPU FSM and the IO requester:
// CPU priority, anti-starvation for IO, bounded IO burst lock, 1-cycle read return.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WAIT   = 4,
  parameter int BURST_MAX  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  io_req,
  input  logic                  io_we,
  input  logic                  io_lock,
  input  logic [ADDR_WIDTH-1:0] io_addr,
  input  logic [DATA_WIDTH-1:0] io_wdata,
  output logic                  io_gnt,
  output logic                  io_rvalid,
  output logic [DATA_WIDTH-1:0] io_rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);

  arb_state_e            state_p1, state_nxt;
  logic [CNT_W-1:0]      burst_cnt_p1, burst_cnt_nxt;
  owner_e                owner_p1;
  logic                  starved;
  logic                  burst_cont, burst_done;
  logic                  cpu_win, io_win;
  logic [ADDR_WIDTH-1:0] mem_addr_p1;
  logic [DATA_WIDTH-1:0] mem_wdata_p1;
  logic [DATA_WIDTH-1:0] cpu_rdata_p1, io_rdata_p1;

  arb_starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .io_req  (io_req),
    .io_gnt  (io_gnt),
    .starved (starved)
  );

  assign cpu_gnt = cpu_win;
  assign io_gnt  = io_win;

  // Stage p0: grant decision, burst FSM next state and memory command mux.
  always_comb begin
    burst_done = (state_p1 == IO_BURST) && (burst_cnt_p1 == BURST_LIM);
    burst_cont = (state_p1 == IO_BURST) && io_req && io_lock && (burst_cnt_p1 < BURST_LIM);

    io_win  = 1'b0;
    cpu_win = 1'b0;
    if (reset) begin
      if (burst_cont) begin
        io_win = 1'b1;
      end else begin
        // A burst that ran to its limit hands the next slot to the CPU.
        io_win  = io_req && (!cpu_req || (starved && !burst_done));
        cpu_win = cpu_req && !io_win;
      end
    end

    state_nxt     = ARB;
    burst_cnt_nxt = '0;
    if (burst_cont) begin
      state_nxt     = IO_BURST;
      burst_cnt_nxt = burst_cnt_p1 + CNT_W'(1);
    end else if (io_win && io_lock) begin
      state_nxt     = IO_BURST;
      burst_cnt_nxt = CNT_W'(1);
    end

    mem_we    = 1'b0;
    mem_addr  = mem_addr_p1;
    mem_wdata = mem_wdata_p1;
    if (cpu_win) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (io_win) begin
      mem_we    = io_we;
      mem_addr  = io_addr;
      mem_wdata = io_wdata;
    end
  end

  // Stage p1: arbitration state, read owner and last driven address/data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p1     <= ARB;
      burst_cnt_p1 <= '0;
      owner_p1     <= OWN_NONE;
      mem_addr_p1  <= '0;
      mem_wdata_p1 <= '0;
    end else begin
      state_p1     <= state_nxt;
      burst_cnt_p1 <= burst_cnt_nxt;
      owner_p1     <= read_owner(cpu_win, cpu_we, io_win, io_we);
      if (cpu_win || io_win) begin
        mem_addr_p1  <= mem_addr;
        mem_wdata_p1 <= mem_wdata;
      end
    end
  end

  assign cpu_rvalid = (owner_p1 == OWN_CPU);
  assign io_rvalid  = (owner_p1 == OWN_IO);

  // Each side keeps its last returned word so the shared bus never leaks across.
  always_ff @(posedge clk) begin
    if (cpu_rvalid) cpu_rdata_p1 <= mem_rdata;
    if (io_rvalid) io_rdata_p1 <= mem_rdata;
  end

  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_p1;
  assign io_rdata  = io_rvalid ? mem_rdata : io_rdata_p1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus hand sequences for
// read-data hold, IO burst limit and reset during an in-flight read.
module tb_mem_port_arbiter;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [15:0] Z = 16'h0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        io_req, io_we, io_lock, io_gnt, io_rvalid;
  logic [15:0] io_addr, io_wdata, io_rdata;
  logic        mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (16),
    .MAX_WAIT   (4),
    .BURST_MAX  (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .io_req     (io_req),
    .io_we      (io_we),
    .io_lock    (io_lock),
    .io_addr    (io_addr),
    .io_wdata   (io_wdata),
    .io_gnt     (io_gnt),
    .io_rvalid  (io_rvalid),
    .io_rdata   (io_rdata),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    logic        cr, cw;
    logic [15:0] ca, cd;
    logic        ir, iw, il;
    logic [15:0] ia, id, mrd;
    logic        ecg, eig, ewe;
    logic [15:0] ema;
    logic        ecv;
    logic [15:0] ecd;
    logic        eiv;
    logic [15:0] eid;
  } vec_t;

  vec_t tbl[$];
  vec_t v;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
                       input logic ir, input logic iw, input logic il,
                       input logic [15:0] ia, input logic [15:0] id, input logic [15:0] mrd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    io_req = ir; io_we = iw; io_lock = il; io_addr = ia; io_wdata = id;
    mem_rdata = mrd;
  endtask

  initial begin
    int n_io;
    bit cpu_done;
    logic e_io, e_cpu;

    // Reset held low with both requesters active: everything must stay quiet.
    reset = 1'b0;
    drive(H, H, 16'h1111, 16'h2222, H, H, H, 16'h3333, 16'h4444, 16'h5555);
    #2;
    chk1("rst cpu_gnt", cpu_gnt, L);
    chk1("rst io_gnt", io_gnt, L);
    chk1("rst mem_we", mem_we, L);
    chk16("rst mem_addr", mem_addr, Z);
    chk16("rst mem_wdata", mem_wdata, Z);
    chk1("rst cpu_rvalid", cpu_rvalid, L);
    chk1("rst io_rvalid", io_rvalid, L);
    @(negedge clk);
    reset = 1'b1;
    drive(L, L, Z, Z, L, L, L, Z, Z, Z);

    // Basic CPU read / write and IO read.
    v = '{H,L,16'h0010,Z, L,L,L,Z,Z, Z,           H,L,L,16'h0010, L,Z, L,Z}; tbl.push_back(v);
    v = '{L,L,Z,Z, L,L,L,Z,Z, 16'hBEEF,           L,L,L,16'h0010, H,16'hBEEF, L,Z}; tbl.push_back(v);
    v = '{H,H,16'h0020,16'h1234, L,L,L,Z,Z, Z,    H,L,H,16'h0020, L,Z, L,Z}; tbl.push_back(v);
    v = '{L,L,Z,Z, L,L,L,Z,Z, Z,                  L,L,L,16'h0020, L,Z, L,Z}; tbl.push_back(v);
    v = '{L,L,Z,Z, H,L,L,16'h0030,Z, Z,           L,H,L,16'h0030, L,Z, L,Z}; tbl.push_back(v);
    v = '{L,L,Z,Z, L,L,L,Z,Z, 16'h5555,           L,L,L,16'h0030, L,Z, H,16'h5555}; tbl.push_back(v);
    // Alternating CPU read then IO read.
    v = '{H,L,16'h0001,Z, L,L,L,Z,Z, Z,           H,L,L,16'h0001, L,Z, L,Z}; tbl.push_back(v);
    v = '{L,L,Z,Z, H,L,L,16'h0002,Z, 16'h1111,    L,H,L,16'h0002, H,16'h1111, L,Z}; tbl.push_back(v);
    v = '{L,L,Z,Z, L,L,L,Z,Z, 16'h2222,           L,L,L,16'h0002, L,Z, H,16'h2222}; tbl.push_back(v);
    // Both requesting continuously: CPU x4, IO x1, repeating.
    for (int r = 0; r < 2; r++) begin
      v = '{H,H,16'h0040,16'h00C0, H,H,L,16'h0050,16'h00D0, Z, H,L,H,16'h0040, L,Z, L,Z};
      for (int k = 0; k < 4; k++) tbl.push_back(v);
      v = '{H,H,16'h0040,16'h00C0, H,H,L,16'h0050,16'h00D0, Z, L,H,H,16'h0050, L,Z, L,Z};
      tbl.push_back(v);
    end
    v = '{L,L,Z,Z, L,L,L,Z,Z, Z,                  L,L,L,16'h0050, L,Z, L,Z}; tbl.push_back(v);
    // wait_cnt holds while io_req is low.
    v = '{H,H,16'h0060,16'h00E0, H,H,L,16'h0070,16'h00F0, Z, H,L,H,16'h0060, L,Z, L,Z};
    tbl.push_back(v); tbl.push_back(v);
    v = '{H,H,16'h0060,16'h00E0, L,H,L,16'h0070,16'h00F0, Z, H,L,H,16'h0060, L,Z, L,Z};
    tbl.push_back(v);
    v = '{H,H,16'h0060,16'h00E0, H,H,L,16'h0070,16'h00F0, Z, H,L,H,16'h0060, L,Z, L,Z};
    tbl.push_back(v); tbl.push_back(v);
    v = '{H,H,16'h0060,16'h00E0, H,H,L,16'h0070,16'h00F0, Z, L,H,H,16'h0070, L,Z, L,Z};
    tbl.push_back(v);
    v = '{L,L,Z,Z, L,L,L,Z,Z, Z,                  L,L,L,16'h0070, L,Z, L,Z}; tbl.push_back(v);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd, tbl[i].ir, tbl[i].iw, tbl[i].il,
            tbl[i].ia, tbl[i].id, tbl[i].mrd);
      #2;
      chk1($sformatf("v%0d cpu_gnt", i), cpu_gnt, tbl[i].ecg);
      chk1($sformatf("v%0d io_gnt", i), io_gnt, tbl[i].eig);
      chk1($sformatf("v%0d mem_we", i), mem_we, tbl[i].ewe);
      chk16($sformatf("v%0d mem_addr", i), mem_addr, tbl[i].ema);
      if (tbl[i].ecg) chk16($sformatf("v%0d mem_wdata", i), mem_wdata, tbl[i].cd);
      if (tbl[i].eig) chk16($sformatf("v%0d mem_wdata", i), mem_wdata, tbl[i].id);
      chk1($sformatf("v%0d cpu_rvalid", i), cpu_rvalid, tbl[i].ecv);
      chk1($sformatf("v%0d io_rvalid", i), io_rvalid, tbl[i].eiv);
      if (tbl[i].ecv) chk16($sformatf("v%0d cpu_rdata", i), cpu_rdata, tbl[i].ecd);
      if (tbl[i].eiv) chk16($sformatf("v%0d io_rdata", i), io_rdata, tbl[i].eid);
    end

    // Non-owner rdata holds its last value while the bus carries the other's data.
    @(negedge clk);
    drive(H, L, 16'h0003, Z, L, L, L, Z, Z, 16'h0BAD);
    #2;
    chk1("hold cpu_gnt", cpu_gnt, H);
    chk16("hold io_rdata a", io_rdata, 16'h2222);
    @(negedge clk);
    drive(L, L, Z, Z, L, L, L, Z, Z, 16'hAAAA);
    #2;
    chk1("hold cpu_rvalid", cpu_rvalid, H);
    chk16("hold cpu_rdata", cpu_rdata, 16'hAAAA);
    chk1("hold io_rvalid", io_rvalid, L);
    chk16("hold io_rdata b", io_rdata, 16'h2222);
    @(negedge clk);
    drive(L, L, Z, Z, H, L, L, 16'h0004, Z, 16'h0BAD);
    #2;
    chk1("hold io_gnt", io_gnt, H);
    chk1("hold cpu_rvalid one-shot", cpu_rvalid, L);
    chk16("hold cpu_rdata kept", cpu_rdata, 16'hAAAA);
    @(negedge clk);
    drive(L, L, Z, Z, L, L, L, Z, Z, 16'hBBBB);
    #2;
    chk1("hold io_rvalid2", io_rvalid, H);
    chk16("hold io_rdata2", io_rdata, 16'hBBBB);
    chk16("hold cpu_rdata2", cpu_rdata, 16'hAAAA);
    @(negedge clk);
    drive(L, L, Z, Z, L, L, L, Z, Z, 16'hCCCC);
    #2;
    chk1("hold io_rvalid one-shot", io_rvalid, L);
    chk16("hold io_rdata3", io_rdata, 16'hBBBB);
    chk16("hold cpu_rdata3", cpu_rdata, 16'hAAAA);

    // IO locked write burst of 10 against a waiting CPU: 8 IO, 1 CPU, then IO resumes.
    n_io = 0;
    cpu_done = 1'b0;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      drive((c >= 1) && !cpu_done, H, 16'h0200, 16'hC0DE,
            (n_io < 10), H, H, 16'h0100 + 16'(n_io), 16'h5A00 + 16'(n_io), Z);
      #2;
      e_io  = (c < 8) || (c == 9) || (c == 10);
      e_cpu = (c == 8);
      chk1($sformatf("burst c%0d io_gnt", c), io_gnt, e_io);
      chk1($sformatf("burst c%0d cpu_gnt", c), cpu_gnt, e_cpu);
      chk1($sformatf("burst c%0d mem_we", c), mem_we, H);
      chk16($sformatf("burst c%0d mem_addr", c), mem_addr,
            e_io ? 16'h0100 + 16'(n_io) : 16'h0200);
      if (io_gnt) n_io++;
      if (cpu_gnt) cpu_done = 1'b1;
    end
    @(negedge clk);
    drive(L, L, Z, Z, L, L, L, Z, Z, Z);

    // Build up wait_cnt, then reset during an in-flight CPU read.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive(H, H, 16'h0300, 16'h0001, H, H, L, 16'h0310, 16'h0002, Z);
      #2;
      chk1($sformatf("pre-rst c%0d cpu_gnt", c), cpu_gnt, H);
    end
    @(negedge clk);
    drive(H, L, 16'h0077, Z, L, L, L, Z, Z, Z);
    #2;
    chk1("midrst read cpu_gnt", cpu_gnt, H);
    #1;
    reset = 1'b0;
    drive(L, L, Z, Z, L, L, L, Z, Z, Z);
    #1;
    chk1("midrst cpu_gnt low", cpu_gnt, L);
    chk16("midrst mem_addr", mem_addr, Z);
    reset = 1'b1;
    @(negedge clk);
    drive(L, L, Z, Z, L, L, L, Z, Z, 16'hDEAD);
    #2;
    chk1("postrst cpu_rvalid", cpu_rvalid, L);
    chk1("postrst io_rvalid", io_rvalid, L);
    chk1("postrst mem_we", mem_we, L);
    chk16("postrst mem_addr", mem_addr, Z);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(H, H, 16'h0300, 16'h0001, H, H, L, 16'h0310, 16'h0002, Z);
      #2;
      chk1($sformatf("postrst c%0d cpu_gnt", c), cpu_gnt, (c < 4) ? H : L);
      chk1($sformatf("postrst c%0d io_gnt", c), io_gnt, (c == 4) ? H : L);
    end
    @(negedge clk);
    drive(L, L, Z, Z, L, L, L, Z, Z, Z);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
